// File: rtl/stopwatch_display_mux_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_disp_pkg
// Shared constants and types for the stopwatch display scanner.
//   SEG_0..SEG_9, SEG_DASH, SEG_OFF : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   digit_idx_t                     : 3-bit scan slot index (0 = s2 ... 5 = h1)
//   DP_IDX_M2, DP_IDX_H2            : slots whose decimal point is lit
//   snap_t                          : 20-bit frame snapshot of the six BCD digits
// ---------------------------------------------------------------------------
package stopwatch_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t IDX_LAST  = 3'd5;
  localparam digit_idx_t DP_IDX_M2 = 3'd2;
  localparam digit_idx_t DP_IDX_H2 = 3'd4;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h2;
    logic [2:0] m1;
    logic [3:0] m2;
    logic [2:0] s1;
    logic [3:0] s2;
  } snap_t;

endpackage

// File: rtl/stopwatch_display_mux_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to active-low 7-segment decoder. Codes 10..15 show a dash
// so an out-of-range digit is visible rather than silently wrong.
//   i_digit : 4-bit digit value
//   o_seg   : {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_decode
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Plain lookup; anything beyond 9 falls into the dash glyph.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_mux.sv
// ---------------------------------------------------------------------------
// stopwatch_display_mux
// Six-digit multiplexed 7-segment scanner for the stopwatch time hh:mm:ss.
// Digits are captured into a snapshot only at frame boundaries so a frame
// never shows a mix of old and new time; i_hold freezes the snapshot (lap).
// Each slot starts with DEAD_CYCLES clocks of all anodes off (anti-ghosting).
//   Parameters : SCAN_DIV (clocks per slot, >= 2), DEAD_CYCLES (< SCAN_DIV)
//   i_clk, i_reset (async, active-high), i_hold
//   i_h1[1:0] i_h2[3:0] i_m1[2:0] i_m2[3:0] i_s1[2:0] i_s2[3:0] : BCD digits
//   o_seg[6:0] {g..a}, o_dp, o_an[5:0] (an[0]=s2 .. an[5]=h1), all active-low
// Optional: define STOPWATCH_DISP_BLANK_EN for leading-zero blanking of
// h1, h2 and m1.
// ---------------------------------------------------------------------------
module stopwatch_display_mux
  import stopwatch_disp_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hold,
  input  logic [1:0] i_h1,
  input  logic [3:0] i_h2,
  input  logic [2:0] i_m1,
  input  logic [3:0] i_m2,
  input  logic [2:0] i_s1,
  input  logic [3:0] i_s2,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [5:0] o_an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYCLES);

  logic [PW-1:0] r_presc;
  digit_idx_t    r_idx;
  snap_t         r_snap;

  logic       w_terminal;
  logic       w_boundary;
  logic       w_dead;
  logic       w_blank;
  logic [3:0] w_digit;
  logic [6:0] w_glyph;
  logic [6:0] w_seg_nxt;
  logic [5:0] w_an_nxt;
  logic       w_dp_nxt;

  assign w_terminal = (r_presc == PRESC_LAST);
  assign w_boundary = w_terminal && (r_idx == IDX_LAST);
  assign w_dead     = (r_presc < DEAD_LIM);

  // Slot timing: prescaler runs 0..SCAN_DIV-1, and the digit index steps
  // once per prescaler wrap, cycling through the six slots.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_terminal) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? digit_idx_t'(0) : r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Snapshot loads on the same edge the index wraps 5->0, so slot 0 of the
  // new frame already sees the new time. Hold is sampled on that edge too,
  // which lets a frame in progress finish on the old snapshot.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_snap <= '0;
    end else if (w_boundary && !i_hold) begin
      r_snap <= '{h1: i_h1, h2: i_h2, m1: i_m1, m2: i_m2, s1: i_s1, s2: i_s2};
    end
  end

  // Pick the snapshot digit for the current slot; narrow digits are
  // zero-extended so they can only ever decode to 0..7.
  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      3'd0:    w_digit = r_snap.s2;
      3'd1:    w_digit = {1'b0, r_snap.s1};
      3'd2:    w_digit = r_snap.m2;
      3'd3:    w_digit = {1'b0, r_snap.m1};
      3'd4:    w_digit = r_snap.h2;
      3'd5:    w_digit = {2'b00, r_snap.h1};
      default: w_digit = 4'd0;
    endcase
  end

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_glyph)
  );

`ifdef STOPWATCH_DISP_BLANK_EN
  // Leading-zero blanking: a leading digit goes dark only when it and every
  // more significant digit are zero. m2 and below are always shown.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      3'd5:    w_blank = (r_snap.h1 == 2'd0);
      3'd4:    w_blank = (r_snap.h1 == 2'd0) && (r_snap.h2 == 4'd0);
      3'd3:    w_blank = (r_snap.h1 == 2'd0) && (r_snap.h2 == 4'd0) &&
                         (r_snap.m1 == 3'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  // Next-output logic: dark during the dead time or when blanked, otherwise
  // one anode low with the decoded glyph; dp separates hh.mm.ss.
  always_comb begin
    w_an_nxt  = 6'b111111;
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if (!w_dead && !w_blank) begin
      w_an_nxt  = ~(6'b000001 << r_idx);
      w_seg_nxt = w_glyph;
      w_dp_nxt  = !((r_idx == DP_IDX_M2) || (r_idx == DP_IDX_H2));
    end
  end

  // All three outputs register on the same edge so anode and segment
  // changes never straddle a clock, avoiding ghost flashes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_an  <= 6'b111111;
      o_seg <= SEG_OFF;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= w_an_nxt;
      o_seg <= w_seg_nxt;
      o_dp  <= w_dp_nxt;
    end
  end

endmodule

// File: doc/stopwatch_display_mux.md
# stopwatch_display_mux

Multiplexed six-digit 7-segment scanner downstream of `stopwatch`. It consumes the stopwatch's BCD time digits `h1 h2 : m1 m2 : s1 s2` and drives one shared active-low segment bus plus six active-low digit anodes. A tear-free snapshot register updates the digits only at frame boundaries. A `hold` input freezes the shown time for lap display while the stopwatch keeps counting.

## Interface
- `SCAN_DIV`, default 1000: clocks per digit slot; must be ≥ 2.
- `DEAD_CYCLES`, default 8: clocks at the start of each slot with all anodes off (anti-ghosting); must be < `SCAN_DIV`.
- `clk`  in  1: system clock, the same clock as `stopwatch`.
- `reset`  in  1: asynchronous, active-high.
- `hold`  in  1: level, sampled on `clk`; 1 freezes the snapshot.
- `h1`  in  2: hours tens (0–2).
- `h2`  in  4: hours ones (BCD).
- `m1`  in  3: minutes tens (0–5).
- `m2`  in  4: minutes ones (BCD).
- `s1`  in  3: seconds tens (0–5).
- `s2`  in  4: seconds ones (BCD).
- `seg`  out  7: `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1: decimal point, active-low.
- `an`  out  6: digit anodes, active-low; `an[0]` = `s2` … `an[5]` = `h1`.

## Operation
- Prescaler counts 0..`SCAN_DIV`-1. At terminal count the digit index advances 0→1→…→5→0.
- Frame boundary: prescaler at terminal count while the index is 5.
- Snapshot register, 20 bits:
  - loads all six inputs at a frame boundary when `hold`=0;
  - when `hold`=1, no loads occur;
  - raising `hold` mid-frame lets the current frame finish on the existing snapshot;
  - after `hold` falls, the next frame boundary loads.
- Digit slot behaviour:
  - prescaler < `DEAD_CYCLES`: `an`=6'b111111, `seg`=7'b1111111, `dp`=1.
  - otherwise: the selected anode is 0, and `seg` = decode of the selected snapshot digit.
- Decode: 0–9 gives standard glyphs. Values 10–15 (only possible on 4-bit digits) give dash `7'b0111111`. Narrow digits are zero-extended before decode.
- `dp`=0 during the lit portions of index 2 (`m2`) and index 4 (`h2`). Otherwise `dp`=1.
- Inputs are assumed synchronous to `clk`; no input synchronisers.

## Timing
- Reset values: prescaler 0, index 0, snapshot all-zero, `an`=6'b111111, `seg`=7'b1111111, `dp`=1.
- Reset is asynchronous and takes effect immediately. The first lit output appears `DEAD_CYCLES`+1 clocks after reset release.
- `seg`, `an` and `dp` are registered: one clock from prescaler/index state to outputs.
- All three outputs change on the same edge, so there is no glitch between anode and segment.
- Frame period = 6×`SCAN_DIV` clocks.
- Snapshot latency: an input change is displayed within at most one frame plus 1 clock after the next boundary.
- Wrap-around: the index wraps 5→0 on the same edge as the snapshot load. Slot 0 of the new frame uses the new snapshot.
- Simultaneous events:
  - `hold` rising on the boundary edge: the load is suppressed (`hold` is sampled on that edge).
  - reset during `hold`: the snapshot clears to 0.

## Configuration
- `STOPWATCH_DISP_BLANK_EN` defined: leading-zero blanking.
  - `h1` blanks if 0.
  - `h2` blanks if `h1`,`h2` are both 0.
  - `m1` blanks if `h1`,`h2`,`m1` are all 0.
  - A blanked slot keeps `an`=6'b111111 and `dp`=1 for its whole duration.
  - `m2`, `s1` and `s2` are always shown.
- Macro undefined: all six digits are always shown; the blanking logic is absent.

## Structure
- Package `stopwatch_disp_pkg` holds:
  - the segment glyph constants (`SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`);
  - the 3-bit digit-index typedef;
  - the dp position constants.
- Sub-module `seg7_decode`: combinational 4-bit BCD to active-low segments, with dash for 10–15.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEAD_CYCLES`=1.
- Reset asserted mid-slot → same timestep `an`=6'b111111, `seg`=7'b1111111, `dp`=1. After release, the first lit slot occurs 2 clocks later with `an`=6'b111110.
- Inputs 12:34:56, run 2 frames → slot `an`=6'b111110 gives `seg`=7'b0000010 ("6"). Slot `an`=6'b111011 gives `seg`=7'b0011001 ("4") with `dp`=0. Frame length is 24 clocks.
- Tearing: change inputs 05:07:09 → 05:07:10 mid-frame → the old digits persist until the boundary; the new "10" appears in slot 0/1 of the next frame.
- Hold: `hold`=1 at 00:00:42, inputs advance to 00:00:50 → the display stays "42". Release `hold` → "50" within one frame.
- `s2`=4'hC → `seg`=7'b0111111 during slot 0.
- Blanking 00:05:07:
  - with `STOPWATCH_DISP_BLANK_EN`: `an[5:3]` never 0, and `m2`="5" is shown with `dp`=0;
  - without the macro: slots 3–5 show `seg`=7'b1000000 ("0").
